interp_symbol_gen: RTL and testbench

- Downstream consumer of the interpolation step registers: reg_E (per-symbol slope), reg_2E and reg_5E.
- Generates the linearly interpolated/extrapolated channel estimate for each OFDM symbol of a slot, anchored on the pilot estimate at symbol 5.
- Output sample k = base + (k-5)*E for stride 1, or base + (2k-5)*E for stride 2.
- One instance per I/Q component. Feeds the equalizer through a valid/ready stream.

---
 rtl/interp_pkg.sv | 17 +
 rtl/interp_symbol_gen_if.sv | 28 ++
 rtl/interp_sat.sv | 23 ++
 rtl/interp_symbol_gen.sv | 91 +++++++++
 tb/tb_interp_symbol_gen.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/interp_pkg.sv
// Shared widths and FSM encoding for the interpolated symbol generator.
package interp_pkg;
  localparam int BASE_W  = 16;
  localparam int REG1    = 17;
  localparam int REG2    = 18;
  localparam int REG3    = 19;
  localparam int ACC_W   = 20;
  localparam int OUT_W   = 16;
  localparam int MAX_SYM = 7;
  localparam int CNT_W   = $clog2(MAX_SYM + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/interp_symbol_gen_if.sv
// Request inputs plus the valid/ready estimate stream toward the equalizer.
interface interp_symbol_gen_if;
  import interp_pkg::*;

  logic                     start;
  logic signed [BASE_W-1:0] base;
  logic signed [REG1-1:0]   reg_E;
  logic signed [REG2-1:0]   reg_2E;
  logic signed [REG3-1:0]   reg_5E;
  logic                     stride;
  logic [CNT_W-1:0]         n_sym;
  logic                     out_ready;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic [CNT_W-1:0]         out_idx;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, base, reg_E, reg_2E, reg_5E, stride, n_sym, out_ready,
    output out_valid, out_data, out_idx, busy, done
  );

  modport master (
    output start, base, reg_E, reg_2E, reg_5E, stride, n_sym, out_ready,
    input  out_valid, out_data, out_idx, busy, done
  );
endinterface

// File: rtl/interp_sat.sv
// Accumulator to output formatting: saturate when INTERP_SAT_EN is defined, wrap otherwise.
module interp_sat
  import interp_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o
);
`ifdef INTERP_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    data_o = acc_i[OUT_W-1:0];
    if (acc_i > MAX_V)      data_o = MAX_V[OUT_W-1:0];
    else if (acc_i < MIN_V) data_o = MIN_V[OUT_W-1:0];
  end
`else
  // Upper bits are intentionally dropped in the wrapping build.
  logic unused_hi;
  assign unused_hi = ^acc_i[ACC_W-1:OUT_W];
  assign data_o    = acc_i[OUT_W-1:0];
`endif
endmodule

// File: rtl/interp_symbol_gen.sv
// Per-slot linear interpolation of the channel estimate anchored at pilot symbol 5.
// Output formatting depends on INTERP_SAT_EN (see interp_sat).
module interp_symbol_gen
  import interp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  interp_symbol_gen_if.slave bus
);
  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q, step_q;
  logic [CNT_W-1:0]        cnt_q, n_lat_q;
  logic                    out_valid_q, busy_q, done_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic [CNT_W-1:0]        out_idx_q;

  logic signed [ACC_W-1:0] acc_init_d, step_init_d, acc_next_d, fmt_in;
  logic signed [OUT_W-1:0] data_d;
  logic                    fire, last;

  // First sample is base - 5E, so the k=5 sample lands back on the pilot.
  assign acc_init_d  = ACC_W'(bus.base) - ACC_W'(bus.reg_5E);
  assign step_init_d = bus.stride ? ACC_W'(bus.reg_2E) : ACC_W'(bus.reg_E);
  assign acc_next_d  = acc_q + step_q;
  assign fmt_in      = (state_q == IDLE) ? acc_init_d : acc_next_d;

  assign fire = out_valid_q & bus.out_ready;
  assign last = (cnt_q == n_lat_q - CNT_W'(1));

  interp_sat u_sat (
    .acc_i  (fmt_in),
    .data_o (data_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      n_lat_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && bus.n_sym != '0) begin
            acc_q       <= acc_init_d;
            step_q      <= step_init_d;
            n_lat_q     <= bus.n_sym;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= data_d;
            out_idx_q   <= '0;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (last) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              acc_q      <= acc_next_d;
              cnt_q      <= cnt_q + CNT_W'(1);
              out_data_q <= data_d;
              out_idx_q  <= cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_interp_symbol_gen.sv
// Directed bench for interp_symbol_gen: nominal, stride 2, backpressure, overflow, start guards, reset.
module tb_interp_symbol_gen;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   expv[7];

  interp_symbol_gen_if bus();

  interp_symbol_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int e, input int e2, input int e5,
                          input logic str, input int n);
    bus.base   = 16'(b);
    bus.reg_E  = 17'(e);
    bus.reg_2E = 18'(e2);
    bus.reg_5E = 19'(e5);
    bus.stride = str;
    bus.n_sym  = 3'(n);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  // Walks a running sequence against expv; optional stall and mid-run start injection.
  task automatic run_seq(input string nm, input int n, input int stall_at, input int stall_n,
                         input int inj_at);
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk({nm, " stall valid"}, 32'(bus.out_valid), 1);
          chk({nm, " stall data"},  32'(bus.out_data), expv[k]);
          chk({nm, " stall idx"},   32'(bus.out_idx), k);
          step();
        end
        bus.out_ready = 1'b1;
      end
      chk({nm, " valid"}, 32'(bus.out_valid), 1);
      chk({nm, " data"},  32'(bus.out_data), expv[k]);
      chk({nm, " idx"},   32'(bus.out_idx), k);
      chk({nm, " busy"},  32'(bus.busy), 1);
      if (k == inj_at) begin
        bus.base  = 16'sd5000;
        bus.start = 1'b1;
      end
      step();
      bus.start = 1'b0;
    end
    chk({nm, " done pulse"}, 32'(bus.done), 1);
    chk({nm, " done valid"}, 32'(bus.out_valid), 0);
    chk({nm, " done busy"},  32'(bus.busy), 1);
    // A start presented in the DONE cycle must be dropped.
    bus.n_sym = 3'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({nm, " idle done"}, 32'(bus.done), 0);
    chk({nm, " idle busy"}, 32'(bus.busy), 0);
    step();
    chk({nm, " no restart"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.base = '0; bus.reg_E = '0; bus.reg_2E = '0; bus.reg_5E = '0;
    bus.stride = 1'b0; bus.n_sym = '0; bus.out_ready = 1'b1;
    #2;
    chk("rst valid", 32'(bus.out_valid), 0);
    chk("rst data",  32'(bus.out_data), 0);
    chk("rst idx",   32'(bus.out_idx), 0);
    chk("rst busy",  32'(bus.busy), 0);
    chk("rst done",  32'(bus.done), 0);
    step(); step();
    rst = 1'b1;
    step();

    expv = '{950, 960, 970, 980, 990, 1000, 1010};
    do_start(1000, 10, 20, 50, 1'b0, 7);
    run_seq("basic", 7, -1, 0, -1);

    expv = '{950, 970, 990, 1010, 1030, 1050, 1070};
    do_start(1000, 10, 20, 50, 1'b1, 7);
    run_seq("stride2", 7, -1, 0, -1);

    expv = '{950, 960, 970, 980, 990, 1000, 1010};
    do_start(1000, 10, 20, 50, 1'b0, 7);
    run_seq("bp", 7, 2, 3, -1);

`ifdef INTERP_SAT_EN
    expv = '{27000, 28000, 29000, 30000, 31000, 32000, 32767};
`else
    expv = '{27000, 28000, 29000, 30000, 31000, 32000, -32536};
`endif
    do_start(32000, 1000, 2000, 5000, 1'b0, 7);
    run_seq("ovf", 7, -1, 0, -1);

    expv = '{950, 960, 970, 980, 990, 1000, 1010};
    do_start(1000, 10, 20, 50, 1'b0, 7);
    run_seq("startprot", 7, -1, 0, 3);

    do_start(1000, 10, 20, 50, 1'b0, 0);
    chk("nsym0 valid", 32'(bus.out_valid), 0);
    chk("nsym0 busy",  32'(bus.busy), 0);
    step();
    chk("nsym0 done",  32'(bus.done), 0);
    chk("nsym0 valid2", 32'(bus.out_valid), 0);

    expv = '{950, 960, 970, 980, 990, 1000, 1010};
    do_start(1000, 10, 20, 50, 1'b0, 7);
    for (int k = 0; k < 4; k++) begin
      chk("prereset data", 32'(bus.out_data), expv[k]);
      step();
    end
    chk("prereset idx", 32'(bus.out_idx), 4);
    rst = 1'b0;
    #1;
    chk("midrst valid", 32'(bus.out_valid), 0);
    chk("midrst busy",  32'(bus.busy), 0);
    chk("midrst data",  32'(bus.out_data), 0);
    chk("midrst idx",   32'(bus.out_idx), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("midrst done", 32'(bus.done), 0);
    end
    rst = 1'b1;
    step();
    expv = '{950, 970, 990, 1010, 1030, 1050, 1070};
    do_start(1000, 10, 20, 50, 1'b1, 5);
    run_seq("postrst", 5, -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
